// File: rtl/shifter_pkg.sv
// Shared op codes, internal shift-mode encoding and elaboration helpers for
// the pipelined operand-2 barrel shifter.
package shifter_pkg;

  localparam logic [2:0] SHIFT_LSL  = 3'b000;
  localparam logic [2:0] SHIFT_LSR  = 3'b001;
  localparam logic [2:0] SHIFT_ASR  = 3'b010;
  localparam logic [2:0] SHIFT_ROR  = 3'b011;
  localparam logic [2:0] SHIFT_RRX  = 3'b100;
  localparam logic [2:0] SHIFT_PASS = 3'b101;

  // Direction/fill selection carried down the mux levels once decode is done
  typedef enum logic [1:0] {
    MODE_LSL,
    MODE_LSR,
    MODE_ASR,
    MODE_ROR
  } shift_mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: applies mux levels [LO, HI) of the binary-weighted
// shift network, then registers the payload when the pipeline advances.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned AMT_W = 5,
  parameter int unsigned LO    = 0,
  parameter int unsigned HI    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_carry,
  input  shift_mode_e       in_mode,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output shift_mode_e       out_mode,
  output logic [AMT_W-1:0]  out_amt,
  output logic [TAG_W-1:0]  out_tag
);

  logic [WIDTH-1:0] lvl [LO:HI];

  assign lvl[LO] = in_data;

  for (genvar k = LO; k < HI; k++) begin : g_lvl
    localparam int unsigned S = 1 << k;
    logic [WIDTH-1:0] shifted;

    always_comb begin
      shifted = lvl[k];
      unique case (in_mode)
        MODE_LSL: shifted = lvl[k] << S;
        MODE_LSR: shifted = lvl[k] >> S;
        MODE_ASR: shifted = $signed(lvl[k]) >>> S;
        MODE_ROR: shifted = (lvl[k] >> S) | (lvl[k] << (WIDTH - S));
      endcase
    end

    assign lvl[k+1] = in_amt[k] ? shifted : lvl[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_mode  <= MODE_LSL;
      out_amt   <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data  <= lvl[HI];
      out_carry <= in_carry;
      out_mode  <= in_mode;
      out_amt   <= in_amt;
      out_tag   <= in_tag;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined ARM operand-2 barrel shifter (LSL/LSR/ASR/ROR/RRX) with
// valid/ready flow control and an in-order sideband tag.
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         shft_op,
  input  logic [WIDTH-1:0]   shift_data,
  input  logic [SHAMT_W-1:0] shift_num,
  input  logic               carry_flag,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   shift_out,
  output logic               shift_carry_out,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned LW  = clog2(WIDTH);
  localparam int unsigned PER = LW / STAGES;
  localparam int unsigned REM = LW % STAGES;

  logic              advance;
  logic              msb;
  logic [LW-1:0]     n_lo;
  logic              n_over;
  logic              n_is_w;
  logic              n_zero;
  logic [LW-1:0]     left_idx;
  logic [LW-1:0]     right_idx;

  logic [WIDTH-1:0]  pre_data;
  logic              pre_carry;
  shift_mode_e       pre_mode;
  logic [LW-1:0]     pre_amt;

  logic              v [0:STAGES];
  logic [WIDTH-1:0]  d [0:STAGES];
  logic              c [0:STAGES];
  shift_mode_e       m [0:STAGES];
  logic [LW-1:0]     a [0:STAGES];
  logic [TAG_W-1:0]  t [0:STAGES];

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  assign msb       = shift_data[WIDTH-1];
  assign n_lo      = shift_num[LW-1:0];
  assign n_over    = |shift_num[SHAMT_W-1:LW];
  assign n_is_w    = (shift_num == SHAMT_W'(WIDTH));
  assign n_zero    = (shift_num == '0);
  assign left_idx  = '0 - n_lo;
  assign right_idx = n_lo - 1'b1;

  // Out-of-range amounts, RRX and PASS are resolved here by substituting the
  // operand and zeroing the amount, so the mux network only ever sees n < WIDTH.
  always_comb begin
    pre_data  = shift_data;
    pre_carry = carry_flag;
    pre_mode  = MODE_LSL;
    pre_amt   = '0;
    case (shft_op)
      SHIFT_LSL: if (!n_zero) begin
        if (!n_over) begin
          pre_amt   = n_lo;
          pre_carry = shift_data[left_idx];
        end else begin
          pre_data  = '0;
          pre_carry = n_is_w & shift_data[0];
        end
      end
      SHIFT_LSR: if (!n_zero) begin
        if (!n_over) begin
          pre_mode  = MODE_LSR;
          pre_amt   = n_lo;
          pre_carry = shift_data[right_idx];
        end else begin
          pre_data  = '0;
          pre_carry = n_is_w & msb;
        end
      end
      SHIFT_ASR: if (!n_zero) begin
        if (!n_over) begin
          pre_mode  = MODE_ASR;
          pre_amt   = n_lo;
          pre_carry = shift_data[right_idx];
        end else begin
          pre_data  = {WIDTH{msb}};
          pre_carry = msb;
        end
      end
      SHIFT_ROR: if (!n_zero) begin
        if (n_lo != '0) begin
          pre_mode  = MODE_ROR;
          pre_amt   = n_lo;
          pre_carry = shift_data[right_idx];
        end else begin
          pre_carry = msb;
        end
      end
      SHIFT_RRX: begin
        pre_data  = {carry_flag, shift_data[WIDTH-1:1]};
        pre_carry = shift_data[0];
      end
      default: ;
    endcase
  end

  assign v[0] = in_valid;
  assign d[0] = pre_data;
  assign c[0] = pre_carry;
  assign m[0] = pre_mode;
  assign a[0] = pre_amt;
  assign t[0] = in_tag;

  // Remainder levels land in the first stage
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = (s == 0) ? 0 : REM + PER * unsigned'(s);
    localparam int unsigned HI = REM + PER * (unsigned'(s) + 1);

    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .AMT_W (LW),
      .LO    (LO),
      .HI    (HI)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .in_valid  (v[s]),
      .in_data   (d[s]),
      .in_carry  (c[s]),
      .in_mode   (m[s]),
      .in_amt    (a[s]),
      .in_tag    (t[s]),
      .out_valid (v[s+1]),
      .out_data  (d[s+1]),
      .out_carry (c[s+1]),
      .out_mode  (m[s+1]),
      .out_amt   (a[s+1]),
      .out_tag   (t[s+1])
    );
  end

  assign out_valid       = v[STAGES];
  assign shift_out       = d[STAGES];
  assign shift_carry_out = c[STAGES];
  assign out_tag         = t[STAGES];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench: the driver queues hand-computed results on acceptance,
// an independent monitor pops and compares whenever a result transfers.
module tb_barrel_shifter_pipe;
  import shifter_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 8;
  localparam int unsigned STAGES  = 2;
  localparam int unsigned TAG_W   = 4;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         shft_op;
  logic [WIDTH-1:0]   shift_data;
  logic [SHAMT_W-1:0] shift_num;
  logic               carry_flag;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   shift_out;
  logic               shift_carry_out;
  logic [TAG_W-1:0]   out_tag;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];

  barrel_shifter_pipe #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .STAGES  (STAGES),
    .TAG_W   (TAG_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .shft_op         (shft_op),
    .shift_data      (shift_data),
    .shift_num       (shift_num),
    .carry_flag      (carry_flag),
    .in_tag          (in_tag),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .shift_out       (shift_out),
    .shift_carry_out (shift_carry_out),
    .out_tag         (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 units after the falling edge, when all driving is settled
  initial begin : monitor
    exp_t        e;
    logic        held;
    logic [31:0] snap_d;
    logic        snap_c;
    logic [3:0]  snap_t;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("in_ready", 32'(in_ready), 32'(out_ready || !out_valid));
        if (held) begin
          check("hold_data",  shift_out,              snap_d);
          check("hold_carry", 32'(shift_carry_out),   32'(snap_c));
          check("hold_tag",   32'(out_tag),           32'(snap_t));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got tag %0d data 0x%08h, expected no output", out_tag, shift_out);
          end else begin
            e = sb.pop_front();
            check("data",  shift_out,            e.d);
            check("carry", 32'(shift_carry_out), 32'(e.c));
            check("tag",   32'(out_tag),         32'(e.tag));
            if (e.lat) check("latency", 32'(cyc - e.acc), STAGES);
          end
        end
        held   = out_valid && !out_ready;
        snap_d = shift_out;
        snap_c = shift_carry_out;
        snap_t = out_tag;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge
  // that follows acceptance, leaving in_valid asserted for back-to-back use.
  task automatic send(input logic [2:0] op, input logic [31:0] dat, input logic [7:0] n,
                      input logic cf, input logic [3:0] tag, input logic [31:0] ed,
                      input logic ec, input bit lat);
    bit ok;
    int acc;
    ok  = 1'b0;
    acc = 0;
    in_valid   = 1'b1;
    shft_op    = op;
    shift_data = dat;
    shift_num  = n;
    carry_flag = cf;
    in_tag     = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok  = in_ready;
      acc = cyc;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    if (ok) sb.push_back('{ed, ec, tag, acc, lat});
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tag %0d not accepted, required acceptance within 50 cycles", tag);
    end
    @(negedge clk);
  endtask

  // Idle cycles drive junk operands that must never be sampled
  task automatic idle(input int n);
    in_valid   = 1'b0;
    shft_op    = 3'b011;
    shift_data = 32'hDEAD_BEEF;
    shift_num  = 8'd7;
    carry_flag = 1'b1;
    in_tag     = 4'hF;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] ror_exp [8] = '{32'h8000_0078, 32'h4000_003C, 32'h2000_001E, 32'h1000_000F,
                               32'h8800_0007, 32'hC400_0003, 32'hE200_0001, 32'hF100_0000};
  logic        ror_c   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] lsr_exp [8] = '{32'h8000_0001, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
                               32'h0800_0000, 32'h0400_0000, 32'h0200_0000, 32'h0100_0000};
  logic        lsr_c   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin : driver
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    shft_op    = '0;
    shift_data = '0;
    shift_num  = '0;
    carry_flag = 1'b0;
    in_tag     = '0;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid),       32'd0);
    check("reset_shift_out", shift_out,            32'd0);
    check("reset_carry",     32'(shift_carry_out), 32'd0);
    check("reset_tag",       32'(out_tag),         32'd0);
    check("reset_in_ready",  32'(in_ready),        32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sweep and boundary amounts
    send(SHIFT_LSL, 32'hAAAA_FF00, 8'd4,    1'b0, 4'd1,  32'hAAAF_F000, 1'b0, 1'b1);
    send(SHIFT_LSR, 32'hAAAA_FF00, 8'd4,    1'b0, 4'd2,  32'h0AAA_AFF0, 1'b0, 1'b1);
    send(SHIFT_ASR, 32'hAAAA_FF00, 8'd4,    1'b0, 4'd3,  32'hFAAA_AFF0, 1'b0, 1'b1);
    send(SHIFT_ROR, 32'hAAAA_FF00, 8'd16,   1'b0, 4'd4,  32'hFF00_AAAA, 1'b1, 1'b1);
    idle(3);
    send(SHIFT_LSL, 32'hAAAA_FF00, 8'h40,   1'b0, 4'd5,  32'h0000_0000, 1'b0, 1'b1);
    send(SHIFT_LSR, 32'hAAAA_FF00, 8'h20,   1'b0, 4'd6,  32'h0000_0000, 1'b1, 1'b1);
    send(SHIFT_ASR, 32'hAAAA_FF00, 8'h40,   1'b0, 4'd7,  32'hFFFF_FFFF, 1'b1, 1'b1);
    send(SHIFT_ROR, 32'hAAAA_FF00, 8'h40,   1'b0, 4'd8,  32'hAAAA_FF00, 1'b1, 1'b1);
    send(SHIFT_LSL, 32'hAAAA_FF00, 8'd0,    1'b1, 4'd9,  32'hAAAA_FF00, 1'b1, 1'b1);
    send(SHIFT_RRX, 32'hAAAA_FF00, 8'd4,    1'b1, 4'd10, 32'hD555_7F80, 1'b0, 1'b1);
    send(3'b111,    32'hAAAA_FF00, 8'd4,    1'b1, 4'd11, 32'hAAAA_FF00, 1'b1, 1'b1);
    idle(2);
    send(SHIFT_LSL, 32'h0000_0001, 8'd32,   1'b0, 4'd12, 32'h0000_0000, 1'b1, 1'b1);
    send(SHIFT_LSR, 32'hFFFF_FFFF, 8'd33,   1'b1, 4'd13, 32'h0000_0000, 1'b0, 1'b1);
    send(SHIFT_ASR, 32'h8000_0000, 8'd31,   1'b0, 4'd14, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send(SHIFT_LSL, 32'h0000_0003, 8'd31,   1'b0, 4'd15, 32'h8000_0000, 1'b1, 1'b1);
    send(SHIFT_ROR, 32'h0000_0001, 8'd1,    1'b0, 4'd0,  32'h8000_0000, 1'b1, 1'b1);
    send(SHIFT_LSR, 32'h0000_0005, 8'd0,    1'b1, 4'd1,  32'h0000_0005, 1'b1, 1'b1);
    send(SHIFT_ROR, 32'h7FFF_FFFF, 8'd32,   1'b1, 4'd2,  32'h7FFF_FFFF, 1'b0, 1'b1);
    send(SHIFT_PASS, 32'h1234_5678, 8'd3,   1'b0, 4'd3,  32'h1234_5678, 1'b0, 1'b1);
    idle(1);
    drain();

    // Back-to-back stream, tags 0..7
    for (int k = 0; k < 8; k++)
      send(SHIFT_LSR, 32'h8000_0001, 8'(k), 1'b0, 4'(k), lsr_exp[k], lsr_c[k], 1'b1);
    idle(1);
    drain();

    // Stream with a 5-cycle consumer stall in the middle
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(SHIFT_ROR, 32'h0000_00F1, 8'(k + 1), 1'b0, 4'(k + 8), ror_exp[k], ror_c[k], 1'b0);
        idle(1);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two results in flight
    send(SHIFT_LSL, 32'hAAAA_FF00, 8'd4, 1'b0, 4'hA, 32'hAAAF_F000, 1'b0, 1'b0);
    send(SHIFT_LSR, 32'hAAAA_FF00, 8'd4, 1'b0, 4'hB, 32'h0AAA_AFF0, 1'b0, 1'b0);
    #1;
    check("inflight_valid", 32'(out_valid), 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", 32'(out_valid),       32'd0);
    check("midreset_shift_out", shift_out,            32'd0);
    check("midreset_carry",     32'(shift_carry_out), 32'd0);
    check("midreset_tag",       32'(out_tag),         32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_reset_idle", 32'(out_valid), 32'd0);
    end
    send(SHIFT_ASR, 32'hAAAA_FF00, 8'd4,  1'b0, 4'hC, 32'hFAAA_AFF0, 1'b0, 1'b1);
    send(SHIFT_ROR, 32'hAAAA_FF00, 8'd16, 1'b0, 4'hD, 32'hFF00_AAAA, 1'b1, 1'b1);
    idle(1);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
